// File: rtl/pattern_matcher_pkg.sv
// Shared constants and helpers for the serial sequence-detector family.
// No logic; elaboration-time values only.
// Default pattern length / counter width and the fill-counter width rule.
package pattern_matcher_pkg;

    localparam int DEF_PAT_LEN = 3;
    localparam int DEF_CNT_W   = 8;

    // Fill counts 0..pat_len inclusive, so it needs room for pat_len+1 values.
    function automatic int fill_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/pattern_matcher_if.sv
// Bundle of serial-input, control and status signals of the pattern matcher.
// Pure wiring, no latency.
// No backpressure: bit_valid qualifies bit_in, the matcher always accepts.
interface pattern_matcher_if
    import pattern_matcher_pkg::*;
#(
    parameter int PAT_LEN = DEF_PAT_LEN,
    parameter int CNT_W   = DEF_CNT_W
);
    localparam int FW = fill_w(PAT_LEN);

    logic               bit_in;
    logic               bit_valid;
    logic [PAT_LEN-1:0] pattern;
    logic               load;
    logic               overlap;
    logic               clr_count;
    logic               seq_detected;
    logic [CNT_W-1:0]   match_count;
    logic [FW-1:0]      fill;

    // Stimulus side: drives the serial stream and controls.
    modport master (
        output bit_in, bit_valid, pattern, load, overlap, clr_count,
        input  seq_detected, match_count, fill
    );

    // Matcher side.
    modport slave (
        input  bit_in, bit_valid, pattern, load, overlap, clr_count,
        output seq_detected, match_count, fill
    );

endinterface

// File: rtl/pattern_matcher_sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
// Count updates on the same edge that samples inc/clr.
// No backpressure; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    localparam logic [W-1:0] CNT_MAX = '1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear wins over the old value but still counts a same-cycle event.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pattern_matcher.sv
// Serial bit-pattern detector: shift-register history compared against a loadable pattern.
// seq_detected pulses the cycle after the bit that completes a match; count updates on that edge.
// No backpressure: every bit with bit_valid=1 is consumed unless load is high the same cycle.
module pattern_matcher
    import pattern_matcher_pkg::*;
#(
    parameter int                 PAT_LEN   = DEF_PAT_LEN,
    parameter int                 CNT_W     = DEF_CNT_W,
    parameter logic [PAT_LEN-1:0] PAT_RESET = PAT_LEN'(3'b101)
) (
    input  logic              clk,
    input  logic              rst,
    pattern_matcher_if.slave  io
);
    localparam int            FW       = fill_w(PAT_LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] pat_q,  pat_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic               seq_q,  seq_d;

    logic [PAT_LEN-1:0] hist_upd;
    logic [FW-1:0]      fill_upd;
    logic               accept;
    logic               match;

    // Match evaluation on the would-be history, plus next-state for all matcher registers.
    always_comb begin
        // A bit presented together with load is dropped: the new pattern starts clean.
        accept   = io.bit_valid & ~io.load;
        hist_upd = {hist_q[PAT_LEN-2:0], io.bit_in};
        fill_upd = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
        match    = accept && (hist_upd == pat_q) && (fill_upd == FILL_MAX);

        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        seq_d  = match;

        if (io.load) begin
            pat_d  = io.pattern;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = hist_upd;
            // Non-overlapping mode only needs fill cleared; stale history bits
            // cannot complete a match until PAT_LEN fresh bits refill it.
            fill_d = (match && !io.overlap) ? '0 : fill_upd;
        end
    end

    // Matcher state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= PAT_RESET;
            hist_q <= '0;
            fill_q <= '0;
            seq_q  <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            seq_q  <= seq_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (io.clr_count),
        .count (io.match_count)
    );

    assign io.seq_detected = seq_q;
    assign io.fill         = fill_q;

endmodule

// File: doc/pattern_matcher.md
PATTERN_MATCHER -- requirements
Module: pattern_matcher

Interface
REQ-001 SHALL have parameter PAT_LEN, default 3, pattern length in bits, legal range 2..16.
REQ-002 SHALL have parameter CNT_W, default 8, width of match counter.
REQ-003 SHALL have parameter PAT_RESET, default 3'b101 (PAT_LEN bits), pattern held after reset.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port bit_in  input  1  serial data bit.
REQ-007 SHALL have port bit_valid  input  1  bit_in sampled only when high.
REQ-008 SHALL have port pattern  input  PAT_LEN  new pattern, MSB = first bit received.
REQ-009 SHALL have port load  input  1  capture pattern and flush history.
REQ-010 SHALL have port overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-011 SHALL have port clr_count  input  1  synchronous clear of match_count.
REQ-012 SHALL have port seq_detected  output  1  one-cycle match pulse.
REQ-013 SHALL have port match_count  output  CNT_W  saturating number of matches.
REQ-014 SHALL have port fill  output  $clog2(PAT_LEN+1)  valid history bits held, 0..PAT_LEN.

Function
REQ-015 SHALL keep a PAT_LEN-bit history shift register; each accepted bit enters at LSB, older bits shift toward MSB.
REQ-016 SHALL increment fill per accepted bit, saturating at PAT_LEN.
REQ-017 SHALL declare a match at the edge accepting a bit when the updated history equals the pattern register and the updated fill equals PAT_LEN.
REQ-018 SHALL drive seq_detected high for exactly the cycle following the matching edge; it SHALL be low in every other cycle, with no combinational path from inputs.
REQ-019 SHALL, with overlap=1, keep history and fill after a match so suffix bits count toward the next match.
REQ-020 SHALL, with overlap=0, clear fill to 0 on a match so the next match needs PAT_LEN fresh bits.
REQ-021 SHALL sample overlap on the same edge as the matching bit; changing it mid-stream SHALL NOT alter history.
REQ-022 SHALL leave history, fill and seq_detected unchanged (seq_detected low) when bit_valid=0.
REQ-023 SHALL, on load=1, capture pattern, clear history and fill to 0, force seq_detected low next cycle, and discard any bit_valid in that cycle.
REQ-024 SHALL NOT clear match_count on load.
REQ-025 SHALL increment match_count by 1 per match, holding at 2^CNT_W-1 (no wrap).
REQ-026 SHALL, on clr_count=1 with no match, set match_count to 0; with a simultaneous match, set it to 1.

Reset
REQ-027 SHALL on rst=1, immediately and regardless of clk, set pattern register to PAT_RESET, history 0, fill 0, seq_detected 0, match_count 0.
REQ-028 SHALL, on reset asserted mid-sequence, discard partial progress; the first match after release needs PAT_LEN new accepted bits.

Structure
REQ-029 SHALL place the fill-width function/constant and default PAT_LEN/CNT_W values in a shared package/include common to the sequence-detector family.
REQ-030 SHALL implement match_count in one sub-module, sat_counter (parameter W; inputs inc, clr; clr+inc yields 1).
REQ-031 SHALL implement matching as shift-register-and-compare, not per-pattern hand-coded states.

Verification
REQ-032 SHALL verify defaults: reset, stream 1,0,1 valid each cycle -> seq_detected pulses once the cycle after the third bit, match_count=1.
REQ-033 SHALL verify overlap: overlap=1, stream 1,0,1,0,1 -> two pulses (after bits 3 and 5), count=2; overlap=0, same stream -> one pulse, count=1.
REQ-034 SHALL verify load: load pattern 3'b110 mid-stream after bits 1,1 -> stream 1,1,0 matches only after the three post-load bits; the bit presented with load is ignored.
REQ-035 SHALL verify gaps and reset: 1, (bit_valid=0 ×3), 0, 1 -> one match; assert rst after bits 1,0 then send 1 -> no match, fill=1.
REQ-036 SHALL verify saturation: CNT_W=2, four matches -> match_count holds 3; clr_count together with a match -> count=1.
REQ-037 SHALL verify PAT_LEN=8, pattern 8'hA5 -> match only after the full 8 bits 1,0,1,0,0,1,0,1; fill reads 8 at match.
